pmem_arbiter: RTL and testbench

Shares the core's single physical-memory port between instruction fetch and the load/store unit. Each requester holds a valid/ready request channel and gets a one-cycle response pulse. The block accepts one request at a time, drives it onto the memory-side handshake and routes the response back to its owner. It sits between the core datapath and the DPI-backed `pmem_read`/`pmem_write` memory model. This lets the core move from a combinational instruction input to multi-cycle fetch and real loads/stores.

---
 rtl/pmem_pkg.sv | 11 +
 rtl/pmem_arb_pick.sv | 39 +++
 rtl/pmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_pmem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// Shared types for the physical-memory arbiter: FSM states, request owner, default widths.
// Pure declarations; no logic, latency or flow control of its own.
package pmem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic       {OWN_IF, OWN_LS}        owner_t;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

endpackage

// File: rtl/pmem_arb_pick.sv
// Fetch vs load/store winner selection with an anti-starvation streak counter.
// Winner is combinational from the valids; the streak updates on the clock, with no stall path of its own.
module pmem_arb_pick
  import pmem_pkg::*;
#(
  parameter int MAX_LS_STREAK = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_idle,
  input  logic   i_if_vld,
  input  logic   i_ls_vld,
  input  logic   i_accept,
  output owner_t o_winner
);

  localparam int            SW         = $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  logic [SW-1:0] r_streak;
  logic          w_fetch_due;

  // Load/store wins by default; a waiting fetch overrides once the streak is used up.
  assign w_fetch_due = i_if_vld && (r_streak == STREAK_MAX);
  assign o_winner    = (i_ls_vld && !w_fetch_due) ? OWN_LS : OWN_IF;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= '0;
    end else if (i_accept && (o_winner == OWN_IF)) begin
      r_streak <= '0;
    end else if (i_idle && !i_if_vld) begin
      r_streak <= '0;
    end else if (i_accept && i_if_vld && (r_streak != STREAK_MAX)) begin
      r_streak <= r_streak + SW'(1);
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between fetch and load/store, one transaction in flight (4 cycles best case).
// Requesters stall on *_req_ready=0 outside IDLE; the memory stalls via mem_req_ready; responses are never backpressured.
module pmem_arbiter
  import pmem_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                ls_req_valid,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wen,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_req_ready,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  owner_t              w_winner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic [DATA_W-1:0]   r_if_data;
  logic [DATA_W-1:0]   r_ls_data;
  logic                w_idle;
  logic                w_if_acc;
  logic                w_ls_acc;
  logic                w_accept;

  assign w_idle   = (r_state == IDLE);
  assign w_if_acc = if_req_valid & if_req_ready;
  assign w_ls_acc = ls_req_valid & ls_req_ready;
  assign w_accept = w_if_acc | w_ls_acc;

  pmem_arb_pick #(
    .MAX_LS_STREAK (MAX_LS_STREAK)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .i_idle   (w_idle),
    .i_if_vld (if_req_valid),
    .i_ls_vld (ls_req_valid),
    .i_accept (w_accept),
    .o_winner (w_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A response arriving alongside mem_req_ready is not sampled: only WAIT looks at mem_resp_valid.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)       w_state_nxt = REQ;
      REQ:     if (mem_req_ready)  w_state_nxt = WAIT;
      WAIT:    if (mem_resp_valid) w_state_nxt = RESP;
      RESP:                        w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if_req_ready = if_req_valid & (w_winner == OWN_IF);
        ls_req_ready = ls_req_valid & (w_winner == OWN_LS);
      end
      REQ:  mem_req_valid = 1'b1;
      RESP: begin
        if_resp_valid = (r_owner == OWN_IF);
        ls_resp_valid = (r_owner == OWN_LS);
      end
      default: ;
    endcase
  end

  // Per-owner response registers so each channel's data holds across the other's traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= OWN_IF;
      r_addr    <= '0;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_if_data <= '0;
      r_ls_data <= '0;
    end else begin
      if (w_if_acc) begin
        r_owner <= OWN_IF;
        r_addr  <= if_req_addr;
        r_wen   <= 1'b0;
        r_wdata <= '0;
        r_wmask <= '0;
      end else if (w_ls_acc) begin
        r_owner <= OWN_LS;
        r_addr  <= ls_req_addr;
        r_wen   <= ls_req_wen;
        r_wdata <= ls_req_wdata;
        r_wmask <= ls_req_wmask;
      end
      if ((r_state == WAIT) && mem_resp_valid) begin
        if (r_owner == OWN_IF) r_if_data <= mem_resp_data;
        else                   r_ls_data <= mem_resp_data;
      end
    end
  end

  assign mem_req_addr  = r_addr;
  assign mem_req_wen   = r_wen;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;
  assign if_resp_data  = r_if_data;
  assign ls_resp_data  = r_ls_data;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed vector table, hand-written corner sequences,
// then random traffic checked against a transaction-level reference model.
module tb_pmem_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int MW   = DW / 8;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready, if_resp_valid;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_resp_data;
  logic          ls_req_valid, ls_req_wen, ls_req_ready, ls_resp_valid;
  logic [AW-1:0] ls_req_addr;
  logic [DW-1:0] ls_req_wdata, ls_resp_data;
  logic [MW-1:0] ls_req_wmask;
  logic          mem_req_valid, mem_req_wen, mem_req_ready, mem_resp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_resp_data;
  logic [MW-1:0] mem_req_wmask;

  always #5 clk = ~clk;

  pmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LS_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] last_if, last_ls;

  typedef struct {
    bit            is_ls;
    bit            wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic [DW-1:0] mdata;
    int            rdly;
    int            sdly;
    bit            exp_wen;
    logic [DW-1:0] exp_wdata;
    logic [MW-1:0] exp_wmask;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0; if_req_addr = '0;
    ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_wen = 1'b0; ls_req_wdata = '0; ls_req_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    if_req_valid = !v.is_ls; if_req_addr = v.addr;
    ls_req_valid = v.is_ls;  ls_req_addr = v.addr; ls_req_wen = v.wen;
    ls_req_wdata = v.wdata;  ls_req_wmask = v.wmask;
    #1;
    check({tag, " accept if_rdy"}, if_req_ready, !v.is_ls);
    check({tag, " accept ls_rdy"}, ls_req_ready, v.is_ls);
    check({tag, " accept mem_vld"}, mem_req_valid, 0);
    step();
    // requesters move on: fields change and both stay valid, readies must stay low
    if_req_valid = 1'b1; ls_req_valid = 1'b1; if_req_addr = ~v.addr; ls_req_addr = ~v.addr;
    ls_req_wen = ~v.wen; ls_req_wdata = ~v.wdata; ls_req_wmask = ~v.wmask;
    for (int k = 0; k <= v.rdly; k++) begin
      mem_req_ready  = (k == v.rdly);
      mem_resp_valid = (k == v.rdly);
      mem_resp_data  = ~v.mdata;
      #1;
      check({tag, " req mem_vld"}, mem_req_valid, 1);
      check({tag, " req addr"}, mem_req_addr, v.addr);
      check({tag, " req wen"}, mem_req_wen, v.exp_wen);
      check({tag, " req wdata"}, mem_req_wdata, v.exp_wdata);
      check({tag, " req wmask"}, mem_req_wmask, v.exp_wmask);
      check({tag, " req rdys"}, {if_req_ready, ls_req_ready}, 0);
      check({tag, " req resp_vlds"}, {if_resp_valid, ls_resp_valid}, 0);
      step();
    end
    mem_req_ready = 1'b0;
    for (int k = 0; k <= v.sdly; k++) begin
      mem_resp_valid = (k == v.sdly);
      mem_resp_data  = (k == v.sdly) ? v.mdata : ~v.mdata;
      #1;
      check({tag, " wait mem_vld"}, mem_req_valid, 0);
      check({tag, " wait rdys"}, {if_req_ready, ls_req_ready}, 0);
      check({tag, " wait resp_vlds"}, {if_resp_valid, ls_resp_valid}, 0);
      step();
    end
    mem_resp_valid = 1'b0;
    #1;
    if (v.is_ls) last_ls = v.mdata; else last_if = v.mdata;
    check({tag, " resp if_vld"}, if_resp_valid, !v.is_ls);
    check({tag, " resp ls_vld"}, ls_resp_valid, v.is_ls);
    check({tag, " resp if_data"}, if_resp_data, last_if);
    check({tag, " resp ls_data"}, ls_resp_data, last_ls);
    check({tag, " resp rdys"}, {if_req_ready, ls_req_ready}, 0);
    step();
    idle_inputs();
    #1;
    check({tag, " after resp_vlds"}, {if_resp_valid, ls_resp_valid}, 0);
    check({tag, " after if_data hold"}, if_resp_data, last_if);
    check({tag, " after ls_data hold"}, ls_resp_data, last_ls);
    check({tag, " after mem_vld"}, mem_req_valid, 0);
    step();
  endtask

  // Random-phase reference model: one outstanding transaction tracked as events.
  bit            m_out, m_hs, m_got, m_own_ls;
  int            m_streak;
  logic [AW-1:0] m_addr;
  logic          m_wen;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_wmask;
  bit            if_pend, ls_pend;

  initial begin
    bit e_if, e_ls, due, e_mv, e_rv;

    vt[0] = '{1'b0, 1'b1, 64'h8000_0000, 64'hDEAD_BEEF_0BAD_F00D, 8'hAA, 64'h0010_0073, 0, 0,
              1'b0, 64'h0, 8'h00};
    vt[1] = '{1'b1, 1'b1, 64'h8000_1000, 64'h1122_3344_5566_7788, 8'hFF, 64'h0000_0000_CAFE_F00D, 0, 0,
              1'b1, 64'h1122_3344_5566_7788, 8'hFF};
    vt[2] = '{1'b1, 1'b0, 64'h8000_2008, 64'h55, 8'h0F, 64'h0123_4567_89AB_CDEF, 5, 3,
              1'b0, 64'h55, 8'h0F};
    vt[3] = '{1'b0, 1'b0, 64'h8000_0004, 64'h1234, 8'h01, 64'h13, 2, 1,
              1'b0, 64'h0, 8'h00};
    vt[4] = '{1'b1, 1'b1, 64'h8000_3000, 64'hA5A5_A5A5_5A5A_5A5A, 8'h0F, 64'hFFFF_0000_FFFF_0000, 1, 2,
              1'b1, 64'hA5A5_A5A5_5A5A_5A5A, 8'h0F};

    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    last_if = '0; last_ls = '0;
    check("reset mem_vld", mem_req_valid, 0);
    check("reset mem_fields", {mem_req_addr, mem_req_wen}, 0);
    check("reset mem_wdata", mem_req_wdata, 0);
    check("reset resp_vlds", {if_resp_valid, ls_resp_valid}, 0);
    check("reset resp_data", {if_resp_data, ls_resp_data}, 0);
    check("reset rdys", {if_req_ready, ls_req_ready}, 0);

    for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Contention: both valid every IDLE cycle, memory immediate.
    for (int g = 0; g < 10; g++) begin
      if_req_valid = 1'b1; if_req_addr = 64'h8000_0000 + 64'(g * 4);
      ls_req_valid = 1'b1; ls_req_addr = 64'h9000_0000 + 64'(g * 8); ls_req_wen = 1'b0;
      #1;
      e_if = (g % 5 == 4);
      check($sformatf("cont%0d if_rdy", g), if_req_ready, e_if);
      check($sformatf("cont%0d ls_rdy", g), ls_req_ready, !e_if);
      step();
      mem_req_ready = 1'b1;
      #1;
      check($sformatf("cont%0d addr", g), mem_req_addr,
            e_if ? 64'h8000_0000 + 64'(g * 4) : 64'h9000_0000 + 64'(g * 8));
      step();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h100 + 64'(g);
      step();
      mem_resp_valid = 1'b0;
      #1;
      check($sformatf("cont%0d resp", g), {if_resp_valid, ls_resp_valid}, e_if ? 2'b10 : 2'b01);
      check($sformatf("cont%0d data", g), e_if ? if_resp_data : ls_resp_data, 64'h100 + 64'(g));
      if (e_if) last_if = 64'h100 + 64'(g); else last_ls = 64'h100 + 64'(g);
      step();
    end
    idle_inputs();
    step();

    // Reset while waiting for the memory response.
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0100;
    #1;
    check("rstwait accept", if_req_ready, 1);
    step();
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    last_if = '0; last_ls = '0;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0200;
    mem_resp_valid = 1'b1; mem_resp_data = 64'hBAD;
    #1;
    check("rstwait mem_vld", mem_req_valid, 0);
    check("rstwait mem_addr", mem_req_addr, 0);
    check("rstwait resp_vlds", {if_resp_valid, ls_resp_valid}, 0);
    check("rstwait resp_data", {if_resp_data, ls_resp_data}, 0);
    check("rstwait first idle rdy", if_req_ready, 1);
    step();
    if_req_valid = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    check("rstwait stale resp", {if_resp_valid, ls_resp_valid}, 0);
    check("rstwait new addr", mem_req_addr, 64'h8000_0200);
    step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h77;
    step();
    mem_resp_valid = 1'b0;
    #1;
    last_if = 64'h77;
    check("rstwait resp", {if_resp_valid, ls_resp_valid}, 2'b10);
    check("rstwait data", if_resp_data, 64'h77);
    step();

    // Spurious response in IDLE, then a request withdrawn before acceptance.
    idle_inputs(); mem_resp_valid = 1'b1; mem_resp_data = 64'hBAD;
    step();
    mem_resp_valid = 1'b0; ls_req_valid = 1'b1; ls_req_addr = 64'h1234;
    #1;
    check("spur resp_vlds", {if_resp_valid, ls_resp_valid}, 0);
    check("spur data hold", if_resp_data, last_if);
    check("spur still idle", ls_req_ready, 1);
    ls_req_valid = 1'b0;
    step();
    #1;
    check("withdraw mem_vld", mem_req_valid, 0);
    check("withdraw resp_vlds", {if_resp_valid, ls_resp_valid}, 0);

    // Random traffic against the reference model.
    rst = 1'b1; idle_inputs();
    step();
    rst = 1'b0;
    m_out = 0; m_hs = 0; m_got = 0; m_own_ls = 0; m_streak = 0;
    m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
    last_if = '0; last_ls = '0; if_pend = 0; ls_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!if_pend && $urandom_range(1, 0) == 1) begin
        if_pend = 1; if_req_addr = {$urandom, $urandom};
      end
      if (!ls_pend && $urandom_range(1, 0) == 1) begin
        ls_pend = 1; ls_req_addr = {$urandom, $urandom}; ls_req_wen = 1'($urandom);
        ls_req_wdata = {$urandom, $urandom}; ls_req_wmask = 8'($urandom);
      end
      if_req_valid   = if_pend;
      ls_req_valid   = ls_pend;
      mem_req_ready  = ($urandom_range(9, 0) < 6);
      mem_resp_valid = ($urandom_range(9, 0) < 4);
      mem_resp_data  = {$urandom, $urandom};
      #1;
      due  = if_pend && (m_streak == MAXS);
      e_if = !m_out && if_pend && (!ls_pend || due);
      e_ls = !m_out && ls_pend && !due;
      e_mv = m_out && !m_hs;
      e_rv = m_out && m_got;
      check("rnd if_rdy", if_req_ready, e_if);
      check("rnd ls_rdy", ls_req_ready, e_ls);
      check("rnd mem_vld", mem_req_valid, e_mv);
      if (e_mv) begin
        check("rnd mem_addr", mem_req_addr, m_addr);
        check("rnd mem_wen", mem_req_wen, m_wen);
        check("rnd mem_wdata", mem_req_wdata, m_wdata);
        check("rnd mem_wmask", mem_req_wmask, m_wmask);
      end
      check("rnd if_resp_vld", if_resp_valid, e_rv && !m_own_ls);
      check("rnd ls_resp_vld", ls_resp_valid, e_rv && m_own_ls);
      check("rnd if_data", if_resp_data, last_if);
      check("rnd ls_data", ls_resp_data, last_ls);
      if (!m_out) begin
        if (e_if) begin
          m_out = 1; m_hs = 0; m_got = 0; m_own_ls = 0; m_streak = 0;
          m_addr = if_req_addr; m_wen = 0; m_wdata = '0; m_wmask = '0; if_pend = 0;
        end else begin
          if (!if_pend) m_streak = 0;
          if (e_ls) begin
            m_out = 1; m_hs = 0; m_got = 0; m_own_ls = 1;
            m_addr = ls_req_addr; m_wen = ls_req_wen; m_wdata = ls_req_wdata; m_wmask = ls_req_wmask;
            if (if_pend && m_streak < MAXS) m_streak++;
            ls_pend = 0;
          end
        end
      end else if (!m_hs) begin
        if (mem_req_ready) m_hs = 1;
      end else if (!m_got) begin
        if (mem_resp_valid) begin
          m_got = 1;
          if (m_own_ls) last_ls = mem_resp_data; else last_if = mem_resp_data;
        end
      end else begin
        m_out = 0;
      end
      if (if_pend && $urandom_range(9, 0) == 0) if_pend = 0;
      if (ls_pend && $urandom_range(9, 0) == 0) ls_pend = 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
